// File: rtl/word_packer_if.sv
// Byte-in / word-out bus of word_packer: UART byte strobes, flush/clear controls,
// FIFO full flag in; FIFO write flag/data, overrun, word count (and optional checksum) out.
// Optional checksum signal present only when PACKER_CHECKSUM_EN is defined.
interface word_packer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   packer_byte_valid_i;
    logic [7:0]             packer_byte_i;
    logic                   packer_flush_i;
    logic                   packer_clear_i;
    logic                   packer_fifofull_i;
    logic                   packer_writeflag_o;
    logic [DATA_WIDTH-1:0]  packer_writedata_o;
    logic                   packer_overrun_o;
    logic [COUNT_WIDTH-1:0] packer_wordcount_o;
`ifdef PACKER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  packer_checksum_o;
`endif

    // Packer side.
    modport master (
        input  packer_byte_valid_i, packer_byte_i, packer_flush_i, packer_clear_i,
               packer_fifofull_i,
        output packer_writeflag_o, packer_writedata_o, packer_overrun_o,
               packer_wordcount_o
`ifdef PACKER_CHECKSUM_EN
        , output packer_checksum_o
`endif
    );

    // Byte source / FIFO side.
    modport slave (
        output packer_byte_valid_i, packer_byte_i, packer_flush_i, packer_clear_i,
               packer_fifofull_i,
        input  packer_writeflag_o, packer_writedata_o, packer_overrun_o,
               packer_wordcount_o
`ifdef PACKER_CHECKSUM_EN
        , input packer_checksum_o
`endif
    );
endinterface

// File: rtl/word_packer.sv
// Packs byte strobes little-endian into DATA_WIDTH words and pushes them to a FIFO.
// Latency: word-completing byte at cycle N -> writeflag at N+1 when FIFO not full.
// Backpressure: one completed word held while FIFO full; a further completion is dropped (overrun).
// Ports: packer_clk_i, packer_rst_i (async, active-high), bus (word_packer_if.master).
// Optional feature macro: PACKER_CHECKSUM_EN adds packer_checksum_o (sum of pushed words).
module word_packer #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic          packer_clk_i,
    input  logic          packer_rst_i,
    word_packer_if.master bus
);
    localparam int BPW   = DATA_WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_PUSH,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  asm_q, asm_d;
    logic [DATA_WIDTH-1:0]  writedata_q, writedata_d;
    logic                   overrun_q, overrun_d;
    logic [COUNT_WIDTH-1:0] wordcount_q, wordcount_d;
`ifdef PACKER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  checksum_q, checksum_d;
`endif

    logic [DATA_WIDTH-1:0]  merged;
    logic                   complete;
    logic                   busy;
    logic                   push;
    logic                   overrun_evt;
    logic                   load;

    always_comb begin
        // Incoming byte is merged before the completion decision, so a same-cycle
        // flush includes it.
        merged = asm_q;
        for (int k = 0; k < BPW; k++) begin
            if (bus.packer_byte_valid_i && idx_q == IDX_W'(k)) begin
                merged[k*8 +: 8] = bus.packer_byte_i;
            end
        end

        complete = (bus.packer_byte_valid_i && idx_q == IDX_W'(BPW - 1)) ||
                   (bus.packer_flush_i && (idx_q != '0 || bus.packer_byte_valid_i));

        busy        = (state_q != S_COLLECT);
        push        = busy && !bus.packer_fifofull_i;
        // Output buffer occupied and not draining this cycle: the new word has nowhere to go.
        overrun_evt = complete && busy && bus.packer_fifofull_i;
        load        = complete && !overrun_evt;

        state_d = state_q;
        if (load) begin
            state_d = S_PUSH;
        end else if (push) begin
            state_d = S_COLLECT;
        end else if (busy) begin
            state_d = S_HOLD;
        end

        writedata_d = load ? merged : writedata_q;

        // Assembly register is zeroed on completion so unfilled lanes of the next word read 0.
        asm_d = complete ? '0 : merged;
        if (complete) begin
            idx_d = '0;
        end else if (bus.packer_byte_valid_i) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end

        // Clear applies first, then the event of the same cycle.
        overrun_d   = overrun_evt ? 1'b1 : (bus.packer_clear_i ? 1'b0 : overrun_q);
        wordcount_d = (bus.packer_clear_i ? '0 : wordcount_q) +
                      {{(COUNT_WIDTH-1){1'b0}}, push};
`ifdef PACKER_CHECKSUM_EN
        checksum_d  = (bus.packer_clear_i ? '0 : checksum_q) +
                      (push ? writedata_q : '0);
`endif
    end

    always_ff @(posedge packer_clk_i or posedge packer_rst_i) begin
        if (packer_rst_i) begin
            state_q     <= S_COLLECT;
            idx_q       <= '0;
            asm_q       <= '0;
            writedata_q <= '0;
            overrun_q   <= 1'b0;
            wordcount_q <= '0;
`ifdef PACKER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            writedata_q <= writedata_d;
            overrun_q   <= overrun_d;
            wordcount_q <= wordcount_d;
`ifdef PACKER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    // The write flag must reflect the full flag of the same cycle so it is never raised
    // into a full FIFO; it is decoded from the registered state, gated by fifofull.
    assign bus.packer_writeflag_o = push;
    assign bus.packer_writedata_o = writedata_q;
    assign bus.packer_overrun_o   = overrun_q;
    assign bus.packer_wordcount_o = wordcount_q;
`ifdef PACKER_CHECKSUM_EN
    assign bus.packer_checksum_o  = checksum_q;
`endif
endmodule

// File: tb/tb_word_packer.sv
// Directed self-checking bench for word_packer.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Pushes are counted at the rising edge, where the FIFO would accept them.
module tb_word_packer;
    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    word_packer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus();

    word_packer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .packer_clk_i (clk),
        .packer_rst_i (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks          = 0;
    int failures        = 0;
    int push_cnt        = 0;
    int flag_while_full = 0;
    int base            = 0;

    always @(posedge clk) begin
        if (bus.packer_writeflag_o === 1'b1) push_cnt++;
        if (bus.packer_writeflag_o === 1'b1 && bus.packer_fifofull_i === 1'b1) flag_while_full++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.packer_byte_valid_i = 1'b1;
        bus.packer_byte_i       = b;
        tick();
        bus.packer_byte_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        bus.packer_flush_i = 1'b1;
        tick();
        bus.packer_flush_i = 1'b0;
    endtask

    initial begin
        bus.packer_byte_valid_i = 1'b0;
        bus.packer_byte_i       = 8'h00;
        bus.packer_flush_i      = 1'b0;
        bus.packer_clear_i      = 1'b0;
        bus.packer_fifofull_i   = 1'b0;

        // Reset state
        #2;
        check("rst_flag", {31'd0, bus.packer_writeflag_o}, 32'd0);
        check("rst_data", bus.packer_writedata_o, 32'h0);
        check("rst_ovr", {31'd0, bus.packer_overrun_o}, 32'd0);
        check("rst_cnt", {16'd0, bus.packer_wordcount_o}, 32'd0);
`ifdef PACKER_CHECKSUM_EN
        check("rst_csum", bus.packer_checksum_o, 32'h0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // 1: basic word, FIFO ready
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t1_noflag", {31'd0, bus.packer_writeflag_o}, 32'd0);
        send_byte(8'h44);
        check("t1_flag", {31'd0, bus.packer_writeflag_o}, 32'd1);
        check("t1_data", bus.packer_writedata_o, 32'h44332211);
        tick();
        check("t1_flag_off", {31'd0, bus.packer_writeflag_o}, 32'd0);
        check("t1_cnt", {16'd0, bus.packer_wordcount_o}, 32'd1);

        // 2: FIFO full across completion, released 5 cycles later
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        bus.packer_fifofull_i = 1'b1;
        send_byte(8'h44);
        check("t2_held0", {31'd0, bus.packer_writeflag_o}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("t2_held", {31'd0, bus.packer_writeflag_o}, 32'd0);
        end
        bus.packer_fifofull_i = 1'b0;
        #1;
        check("t2_flag", {31'd0, bus.packer_writeflag_o}, 32'd1);
        check("t2_data", bus.packer_writedata_o, 32'h44332211);
        tick();
        check("t2_flag_off", {31'd0, bus.packer_writeflag_o}, 32'd0);
        check("t2_cnt", {16'd0, bus.packer_wordcount_o}, 32'd2);

        // 3: overrun while full
        bus.packer_fifofull_i = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("t3_ovr", {31'd0, bus.packer_overrun_o}, 32'd1);
        check("t3_data", bus.packer_writedata_o, 32'h04030201);
        check("t3_noflag", {31'd0, bus.packer_writeflag_o}, 32'd0);
        base = push_cnt;
        bus.packer_fifofull_i = 1'b0;
        tick();
        tick();
        check("t3_one_push", 32'(push_cnt - base), 32'd1);
        check("t3_cnt", {16'd0, bus.packer_wordcount_o}, 32'd3);
        bus.packer_clear_i = 1'b1;
        tick();
        bus.packer_clear_i = 1'b0;
        check("t3_clr_ovr", {31'd0, bus.packer_overrun_o}, 32'd0);
        check("t3_clr_cnt", {16'd0, bus.packer_wordcount_o}, 32'd0);

        // 4: flush of a partial word, lane restart, clear coinciding with push, lone flush
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_flush();
        check("t4_flag", {31'd0, bus.packer_writeflag_o}, 32'd1);
        check("t4_data", bus.packer_writedata_o, 32'h0000BBAA);
        tick();
        check("t4_cnt", {16'd0, bus.packer_wordcount_o}, 32'd1);
        send_byte(8'hCC);
        do_flush();
        check("t4_lane0", bus.packer_writedata_o, 32'h000000CC);
        bus.packer_clear_i = 1'b1;
        tick();
        bus.packer_clear_i = 1'b0;
        check("t4_clr_push_cnt", {16'd0, bus.packer_wordcount_o}, 32'd1);
        base = push_cnt;
        do_flush();
        check("t4_lone_flag", {31'd0, bus.packer_writeflag_o}, 32'd0);
        tick();
        check("t4_lone_nopush", 32'(push_cnt - base), 32'd0);
        // byte and flush in the same cycle: the byte is part of the word
        send_byte(8'hDD);
        bus.packer_flush_i = 1'b1;
        send_byte(8'hEE);
        bus.packer_flush_i = 1'b0;
        check("t4_bf_flag", {31'd0, bus.packer_writeflag_o}, 32'd1);
        check("t4_bf_data", bus.packer_writedata_o, 32'h0000EEDD);
        tick();
        check("t4_bf_cnt", {16'd0, bus.packer_wordcount_o}, 32'd2);

        // 5: reset during a partial word
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_cnt", {16'd0, bus.packer_wordcount_o}, 32'd0);
        check("t5_async_data", bus.packer_writedata_o, 32'h0);
        tick();
        rst = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("t5_flag", {31'd0, bus.packer_writeflag_o}, 32'd1);
        check("t5_data", bus.packer_writedata_o, 32'h04030201);
        tick();
        check("t5_cnt", {16'd0, bus.packer_wordcount_o}, 32'd1);

        // 6: checksum wrap
        bus.packer_clear_i = 1'b1;
        tick();
        bus.packer_clear_i = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        check("t6_data1", bus.packer_writedata_o, 32'hFFFFFFFF);
        tick();
`ifdef PACKER_CHECKSUM_EN
        check("t6_csum1", bus.packer_checksum_o, 32'hFFFFFFFF);
`endif
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t6_data2", bus.packer_writedata_o, 32'h00000002);
        tick();
        check("t6_cnt", {16'd0, bus.packer_wordcount_o}, 32'd2);
`ifdef PACKER_CHECKSUM_EN
        check("t6_csum2", bus.packer_checksum_o, 32'h00000001);
`endif

        check("never_flag_when_full", 32'(flag_while_full), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
